// File: rtl/relogio_pkg.sv
// relogio_pkg: shared types and helpers for the minutes/seconds clock stage
//   state_t : RUN / SET_MIN / SET_SEC operating modes (2-bit encoding)
//   MOD60   : modulus of both the seconds and minutes fields
//   time_t  : 6-bit container for a 0..59 field
//   inc60   : increment a field modulo 60
package relogio_pkg;

    typedef enum logic [1:0] {RUN = 2'd0, SET_MIN = 2'd1, SET_SEC = 2'd2} state_t;

    localparam int MOD60 = 60;

    typedef logic [5:0] time_t;

    function automatic time_t inc60(input time_t v);
        return (v == time_t'(MOD60 - 1)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle rising-edge detector for a synchronized button level
//   clk   : system clock
//   reset : synchronous, active-low reset
//   in    : button level, already synchronized to clk
//   rise  : high while in=1 and the previous sample was 0
// The history register resets to 1, so a button held through reset release
// is not reported as a press.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset)
            prev <= 1'b1;
        else
            prev <= in;
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/relogio_min_seg.sv
// relogio_min_seg: minutes/seconds timebase with button-driven set mode
//   clk      : system clock, rising edge
//   reset    : synchronous, active-low reset
//   hold     : (only with RELOGIO_HOLD_EN) freezes counting while in RUN
//   btn_mode : mode button level, cycles RUN -> SET_MIN -> SET_SEC -> RUN
//   btn_inc  : increment button level, bumps the selected field in SET modes
//   seg      : seconds 0..59
//   min      : minutes 0..59
//   mode     : 0=RUN, 1=SET_MIN, 2=SET_SEC
//   tick     : one-cycle pulse on each prescaler terminal count
//   carry    : one-cycle pulse on the 59:59 -> 00:00 rollover, for the hours stage
// Optional feature macro: RELOGIO_HOLD_EN adds the hold input.
module relogio_min_seg
    import relogio_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       reset,
`ifdef RELOGIO_HOLD_EN
    input  logic       hold,
`endif
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] seg,
    output logic [5:0] min,
    output logic [1:0] mode,
    output logic       tick,
    output logic       carry
);

    localparam int PRESC = CLK_HZ / TICK_HZ;
    localparam int PW    = (PRESC < 2) ? 1 : $clog2(PRESC);

    generate
        if (PRESC < 2) begin : g_bad_presc
            $error("relogio_min_seg: CLK_HZ/TICK_HZ must be >= 2");
        end
    endgenerate

    state_t        state, next_state;
    logic [PW-1:0] presc;
    time_t         seg_q, min_q;
    logic          tick_q, carry_q;
    logic          mode_ev, inc_ev, presc_end, frozen;

    edge_detect u_mode (.clk(clk), .reset(reset), .in(btn_mode), .rise(mode_ev));
    edge_detect u_inc  (.clk(clk), .reset(reset), .in(btn_inc),  .rise(inc_ev));

`ifdef RELOGIO_HOLD_EN
    assign frozen = hold;
`else
    assign frozen = 1'b0;
`endif

    always_comb begin
        next_state = (state == RUN)     ? SET_MIN :
                     (state == SET_MIN) ? SET_SEC : RUN;
    end

    assign presc_end = (presc == PW'(PRESC - 1));

    // A mode event takes priority over everything else in its cycle: the
    // increment is dropped and the prescaler restarts from 0, so leaving
    // SET_SEC gives a full PRESC-cycle wait before the first tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RUN;
            presc   <= '0;
            seg_q   <= '0;
            min_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            if (mode_ev) begin
                state <= next_state;
                presc <= '0;
            end else if (state == RUN) begin
                if (!frozen) begin
                    if (presc_end) begin
                        presc  <= '0;
                        tick_q <= 1'b1;
                        seg_q  <= inc60(seg_q);
                        if (seg_q == time_t'(MOD60 - 1)) begin
                            min_q <= inc60(min_q);
                            if (min_q == time_t'(MOD60 - 1))
                                carry_q <= 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
            end else if (inc_ev) begin
                if (state == SET_MIN)
                    min_q <= inc60(min_q);
                else if (state == SET_SEC)
                    seg_q <= inc60(seg_q);
            end
        end
    end

    assign seg   = seg_q;
    assign min   = min_q;
    assign mode  = state;
    assign tick  = tick_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_relogio_min_seg.sv
// tb_relogio_min_seg: directed self-checking bench for relogio_min_seg (PRESC=10)
module tb_relogio_min_seg;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
`ifdef RELOGIO_HOLD_EN
    logic       hold = 1'b0;
`endif
    logic [5:0] seg, min;
    logic [1:0] mode;
    logic       tick, carry;

    int checks = 0;
    int failures = 0;
    int tk_cnt = 0;
    int cr_cnt = 0;
    int tk0, cr0, cr_loop;

    relogio_min_seg #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk(clk),
        .reset(reset),
`ifdef RELOGIO_HOLD_EN
        .hold(hold),
`endif
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .seg(seg),
        .min(min),
        .mode(mode),
        .tick(tick),
        .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each and tallying pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tk_cnt += int'(tick);
            cr_cnt += int'(carry);
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        step(1);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            btn_inc = 1'b1;
            step(1);
            btn_inc = 1'b0;
            step(1);
        end
    endtask

    initial begin
        // 1: reset with random buttons, then release with btn_mode held high
        for (int i = 0; i < 3; i++) begin
            btn_mode = 1'($urandom);
            btn_inc  = 1'($urandom);
            step(1);
        end
        check("rst_seg", seg, 0);
        check("rst_min", min, 0);
        check("rst_mode", mode, 0);
        check("rst_tick", tick, 0);
        check("rst_carry", carry, 0);
        btn_mode = 1'b1;
        btn_inc  = 1'b0;
        step(1);
        reset = 1'b1;
        tk0 = tk_cnt;
        // 2: first tick exactly 10 edges after release
        for (int i = 1; i <= 9; i++) begin
            step(1);
            if (i == 1) btn_mode = 1'b0;
        end
        check("held_btn_no_mode", mode, 0);
        check("no_early_tick", tk_cnt - tk0, 0);
        step(1);
        check("first_tick", tick, 1);
        check("first_seg", seg, 1);
        step(1);
        check("tick_one_cycle", tick, 0);
        cr0 = cr_cnt;
        tk0 = tk_cnt;
        step(589);
        check("min_rollover_min", min, 1);
        check("min_rollover_seg", seg, 0);
        check("ticks_in_590", tk_cnt - tk0, 59);
        check("no_carry_600", cr_cnt - cr0, 0);
        // 3: load 59:58 through set mode, then watch the 59:59 -> 00:00 carry
        press_mode();
        check("set_min_mode", mode, 1);
        press_inc(58);
        check("set_min_59", min, 59);
        press_mode();
        check("set_sec_mode", mode, 2);
        press_inc(58);
        check("set_sec_58", seg, 58);
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        check("back_to_run", mode, 0);
        cr0 = cr_cnt;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (i == 10) begin
                check("pre_roll_seg", seg, 59);
                check("pre_roll_tick", tick, 1);
                check("pre_roll_carry", carry, 0);
            end
        end
        cr_loop = cr_cnt - cr0;
        check("carry_pulse", carry, 1);
        check("carry_tick", tick, 1);
        check("carry_min0", min, 0);
        check("carry_seg0", seg, 0);
        check("carry_count", cr_loop, 1);
        step(1);
        check("carry_one_cycle", carry, 0);
        // 4: 61 increments in SET_MIN wrap through 59 -> 0 without carry
        tk0 = tk_cnt;
        cr0 = cr_cnt;
        press_mode();
        check("t4_mode", mode, 1);
        for (int i = 1; i <= 61; i++) begin
            press_inc(1);
            if (i == 60) check("inc_wrap_59_0", min, 0);
        end
        check("t4_min", min, 1);
        check("t4_seg", seg, 0);
        check("t4_no_tick", tk_cnt - tk0, 0);
        check("t4_no_carry", cr_cnt - cr0, 0);
        press_inc(11);
        check("t4_min12", min, 12);
        // 5: simultaneous mode and inc events: mode wins
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(1);
        check("t5_mode", mode, 2);
        check("t5_min", min, 12);
        press_inc(30);
        check("t5_seg30", seg, 30);
        // 6: reset mid-run at prescaler=5, 12:30
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        tk0 = tk_cnt;
        step(5);
        check("t6_seg30", seg, 30);
        check("t6_min12", min, 12);
        check("t6_no_tick", tk_cnt - tk0, 0);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check("t6_rst_seg", seg, 0);
        check("t6_rst_min", min, 0);
        check("t6_rst_mode", mode, 0);
        check("t6_rst_tick", tick, 0);
        tk0 = tk_cnt;
        step(9);
        check("t6_no_early_tick", tk_cnt - tk0, 0);
        step(1);
        check("t6_tick", tick, 1);
        check("t6_seg1", seg, 1);
`ifdef RELOGIO_HOLD_EN
        step(3);
        hold = 1'b1;
        tk0 = tk_cnt;
        step(25);
        check("hold_seg", seg, 1);
        check("hold_no_tick", tk_cnt - tk0, 0);
        hold = 1'b0;
        step(6);
        check("hold_resume_wait", tk_cnt - tk0, 0);
        step(1);
        check("hold_resume_tick", tick, 1);
        check("hold_resume_seg", seg, 2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
